// File: rtl/fft_peak_detector_if.sv
// Bin stream into the FFT peak detector and the per-frame peak report coming back out.
interface fft_peak_detector_if #(
  parameter int NB    = 18,
  parameter int LOG_N = 9,
  parameter int MAG_W = 36
) ();
  logic                    bin_valid;
  logic [LOG_N-1:0]        bin_addr;
  logic signed [NB-1:0]    bin_real;
  logic signed [NB-1:0]    bin_imag;
  logic                    peak_valid;
  logic                    peak_found;
  logic [LOG_N-1:0]        peak_bin;
  logic [MAG_W-1:0]        peak_mag;
  logic                    busy;
  logic                    frame_err;

  modport master (
    output bin_valid, bin_addr, bin_real, bin_imag,
    input  peak_valid, peak_found, peak_bin, peak_mag, busy, frame_err
  );

  modport slave (
    input  bin_valid, bin_addr, bin_real, bin_imag,
    output peak_valid, peak_found, peak_bin, peak_mag, busy, frame_err
  );
endinterface

// File: rtl/fft_peak_detector.sv
// Squared-magnitude peak search over one FFT frame; reports the strongest in-band bin.
//
// state  | meaning
// IDLE   | waiting for bin 0 of a frame
// SCAN   | accepting bins in address order
// DRAIN  | last bin accepted, pipeline still carrying it (a new frame may already be scanning)
// REPORT | peak_* updated this cycle
module fft_peak_detector #(
  parameter int NB      = 18,
  parameter int LOG_N   = 9,
  parameter int MAG_W   = 36,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 255,
  parameter logic [MAG_W-1:0] THRESH = MAG_W'(4096)
) (
  input logic clk,
  input logic reset,
  fft_peak_detector_if.slave bus
);
  localparam logic [LOG_N-1:0] LAST_A = '1;
  localparam logic [LOG_N-1:0] MIN_A  = LOG_N'(MIN_BIN);
  localparam logic [LOG_N-1:0] MAX_A  = LOG_N'(MAX_BIN);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  state_t state, state_nxt;
  logic             ovl;
  logic [LOG_N-1:0] exp_addr;
  logic             scan_now, scan_nxt, acc, first, last, err;

  logic                   s1_v, s1_inb, s1_first, s1_last;
  logic [LOG_N-1:0]       s1_addr;
  logic [2*NB-2:0]        s1_re2, s1_im2;
  logic                   s2_v, s2_inb, s2_first, s2_last;
  logic [LOG_N-1:0]       s2_addr;
  logic [MAG_W-1:0]       s2_mag;
  logic                   s3_last;
  logic [MAG_W-1:0]       max_mag, base_mag;
  logic [LOG_N-1:0]       max_bin, base_bin;
  logic                   upd;

  logic signed [2*NB-2:0] re_ext, im_ext;
  logic [2*NB-2:0]        re_sq, im_sq;

  // ovl marks a follow-on frame scanning while the previous one drains/reports
  always_comb begin
    scan_now = (state == SCAN) || (ovl && (state == DRAIN || state == REPORT));
    acc   = 1'b0;
    first = 1'b0;
    err   = 1'b0;
    if (bus.bin_valid) begin
      if (scan_now && bus.bin_addr == exp_addr) begin
        acc = 1'b1;
      end else begin
        err = scan_now;
        if (bus.bin_addr == '0) begin
          acc   = 1'b1;
          first = 1'b1;
        end
      end
    end
    last = acc && (bus.bin_addr == LAST_A);
    if (last)
      scan_nxt = 1'b0;
    else if (acc)
      scan_nxt = 1'b1;
    else if (err)
      scan_nxt = 1'b0;
    else
      scan_nxt = scan_now;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ovl      <= 1'b0;
      exp_addr <= '0;
    end else begin
      state    <= state_nxt;
      ovl      <= scan_nxt && (state_nxt == DRAIN || state_nxt == REPORT);
      if (acc)
        exp_addr <= bus.bin_addr + LOG_N'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DRAIN;
               else if (!scan_nxt) state_nxt = IDLE;
      DRAIN:   if (s3_last) state_nxt = REPORT;
      REPORT:  state_nxt = scan_nxt ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state == SCAN) || (state == DRAIN) || (state == REPORT && ovl);
    bus.peak_valid = (state == REPORT);
  end

  // Sign-extend before squaring so the 35-bit product keeps the exact value.
  assign re_ext = {{(NB-1){bus.bin_real[NB-1]}}, bus.bin_real};
  assign im_ext = {{(NB-1){bus.bin_imag[NB-1]}}, bus.bin_imag};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_comb begin
    base_mag = s2_first ? '0 : max_mag;
    base_bin = s2_first ? MIN_A : max_bin;
    upd      = s2_inb && (s2_mag > base_mag);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v <= 1'b0; s1_inb <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_addr <= '0; s1_re2 <= '0; s1_im2 <= '0;
      s2_v <= 1'b0; s2_inb <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_addr <= '0; s2_mag <= '0;
      s3_last <= 1'b0; max_mag <= '0; max_bin <= '0;
      bus.peak_found <= 1'b0; bus.peak_bin <= '0; bus.peak_mag <= '0;
      bus.frame_err  <= 1'b0;
    end else begin
      s1_v     <= acc;
      s1_first <= first;
      s1_last  <= last;
      s1_addr  <= bus.bin_addr;
      s1_inb   <= (bus.bin_addr >= MIN_A) && (bus.bin_addr <= MAX_A);
      s1_re2   <= re_sq;
      s1_im2   <= im_sq;

      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_addr  <= s1_addr;
      s2_inb   <= s1_inb;
      s2_mag   <= MAG_W'(s1_re2) + MAG_W'(s1_im2);

      if (s2_v) begin
        max_mag <= upd ? s2_mag  : base_mag;
        max_bin <= upd ? s2_addr : base_bin;
      end
      s3_last <= s2_v && s2_last;

      // Report registers are the second buffer: the next frame may clear max_* this same edge.
      if (s3_last) begin
        bus.peak_bin   <= max_bin;
        bus.peak_mag   <= max_mag;
        bus.peak_found <= (max_mag >= THRESH);
      end
      bus.frame_err <= err;
    end
  end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Randomised frames against a frame-level reference model, plus literal checks on the named scenarios.
module tb_fft_peak_detector;
  localparam int N = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_peak_detector_if bus ();
  fft_peak_detector dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int dut_reports = 0;
  int model_reports = 0;

  int fr_re[N];
  int fr_im[N];

  typedef struct { longint due; int bin; longint mag; } rep_t;
  rep_t   pend[$];
  bit     m_scan = 1'b0;
  int     m_next = 0;
  longint m_mags[N];
  longint cyc = 0;
  longint busy_end = -1;
  bit     model_live = 1'b0;
  bit     e_valid = 1'b0, e_found = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  int     e_bin = 0;
  longint e_mag = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peak of a completed frame: strongest in-band bin, lowest index on ties.
  function automatic void find_peak(output int b, output longint m);
    b = 1;
    m = 0;
    for (int i = 1; i <= 255; i++)
      if (m_mags[i] > m) begin
        m = m_mags[i];
        b = i;
      end
  endfunction

  always @(posedge clk) begin : model
    longint mag, ended;
    int a, pb;
    longint pm;
    rep_t r;
    ended = cyc;
    cyc++;
    model_live = 1'b1;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!reset) begin
      m_scan = 1'b0;
      pend.delete();
      busy_end = -1;
      e_found = 1'b0; e_bin = 0; e_mag = 0; e_busy = 1'b0;
    end else begin
      if (bus.bin_valid) begin
        a   = int'(bus.bin_addr);
        mag = longint'(bus.bin_real) * longint'(bus.bin_real)
            + longint'(bus.bin_imag) * longint'(bus.bin_imag);
        if (!(m_scan && a == m_next)) begin
          if (m_scan) begin
            e_err  = 1'b1;
            m_scan = 1'b0;
          end
          if (a == 0) begin
            foreach (m_mags[i]) m_mags[i] = 0;
            m_scan = 1'b1;
            m_next = 0;
          end
        end
        if (m_scan && a == m_next) begin
          m_mags[a] = mag;
          m_next = a + 1;
          if (a == N - 1) begin
            find_peak(pb, pm);
            r.due = ended + 4; r.bin = pb; r.mag = pm;
            pend.push_back(r);
            m_scan = 1'b0;
            busy_end = ended + 3;
          end
        end
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_valid = 1'b1;
        e_bin   = pend[0].bin;
        e_mag   = pend[0].mag;
        e_found = (pend[0].mag >= 4096);
        pend.pop_front();
        model_reports++;
      end
      e_busy = m_scan || (cyc <= busy_end);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("peak_valid", bus.peak_valid, e_valid);
      chk("frame_err",  bus.frame_err,  e_err);
      chk("busy",       bus.busy,       e_busy);
      chk("peak_bin",   bus.peak_bin,   e_bin);
      chk("peak_mag",   bus.peak_mag,   e_mag);
      chk("peak_found", bus.peak_found, e_found);
      if (bus.peak_valid) dut_reports++;
    end
  end

  task automatic send(input int a, input int re, input int im);
    @(negedge clk);
    bus.bin_valid = 1'b1;
    bus.bin_addr  = 9'(a);
    bus.bin_real  = 18'(re);
    bus.bin_imag  = 18'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.bin_valid = 1'b0;
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
  endtask

  task automatic random_frame(input int r);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = int'($urandom_range(2 * r, 0)) - r;
      fr_im[i] = int'($urandom_range(2 * r, 0)) - r;
    end
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < N; i++) begin
      send(i, fr_re[i], fr_im[i]);
      if (max_gap > 0 && i != N - 1) idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic wait_report(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = bus.peak_valid;
    end
    chk(name, got, 1);
  endtask

  initial begin
    bus.bin_valid = 1'b0;
    bus.bin_addr  = '0;
    bus.bin_real  = '0;
    bus.bin_imag  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_peak_mag", bus.peak_mag, 0);
    reset = 1'b1;
    idle(2);

    // single tone at bin 37
    clear_frame();
    fr_re[37] = 1000;
    send_frame(0);
    idle(1);
    wait_report("t1_report");
    chk("t1_bin", bus.peak_bin, 37);
    chk("t1_mag", bus.peak_mag, 1000000);
    chk("t1_found", bus.peak_found, 1);
    chk("t1_model_bin", e_bin, 37);
    idle(3);

    // equal peaks at 20 and 60
    clear_frame();
    fr_re[20] = -300; fr_im[20] = 400;
    fr_re[60] = -300; fr_im[60] = 400;
    send_frame(0);
    idle(1);
    wait_report("t2_report");
    chk("t2_bin", bus.peak_bin, 20);
    chk("t2_mag", bus.peak_mag, 250000);
    idle(3);

    // large out-of-band bins, small in-band peak below threshold
    clear_frame();
    fr_re[0] = 131071; fr_re[300] = 131071;
    fr_re[10] = 10; fr_im[10] = 10;
    send_frame(0);
    idle(1);
    wait_report("t3_report");
    chk("t3_bin", bus.peak_bin, 10);
    chk("t3_mag", bus.peak_mag, 200);
    chk("t3_found", bus.peak_found, 0);
    chk("t3_model_mag", e_mag, 200);
    idle(3);

    // broken address sequence, then a clean frame
    random_frame(5000);
    for (int i = 0; i < 100; i++) send(i, fr_re[i], fr_im[i]);
    send(150, 7, 7);
    @(posedge clk);
    #1;
    chk("t4_frame_err", bus.frame_err, 1);
    idle(10);
    chk("t4_idle_busy", bus.busy, 0);
    random_frame(20000);
    send_frame(1);
    idle(8);

    // reset mid-frame, then a frame peaking at bin 5
    clear_frame();
    fr_re[5] = 3000;
    for (int i = 0; i <= 200; i++) send(i, fr_re[i], fr_im[i]);
    @(negedge clk);
    bus.bin_valid = 1'b0;
    reset = 1'b0;
    idle(2);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_valid", bus.peak_valid, 0);
    reset = 1'b1;
    idle(1);
    send(7, 100, 100);
    idle(2);
    send_frame(0);
    idle(1);
    wait_report("t5_report");
    chk("t5_bin", bus.peak_bin, 5);
    chk("t5_mag", bus.peak_mag, 9000000);
    idle(8);

    // back-to-back frames with gaps; second carries the full-scale bin
    random_frame(100000);
    send_frame(3);
    random_frame(100000);
    fr_re[100] = -131072; fr_im[100] = -131072;
    send_frame(2);
    idle(1);
    wait_report("t6_report");
    chk("t6_bin", bus.peak_bin, 100);
    chk("t6_mag", bus.peak_mag, 64'd34359738368);

    // further random frames, next one starting in the report cycle
    for (int k = 0; k < 3; k++) begin
      idle(3);
      random_frame(int'($urandom_range(60000, 50)));
      send_frame(2);
    end
    idle(10);
    chk("report_count", dut_reports, model_reports);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
